map_table_restore_ctrl: RTL and testbench



---
 rtl/map_table_restore_ctrl_if.sv | 59 +++++
 rtl/map_table_restore_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_map_table_restore_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/map_table_restore_ctrl_if.sv
// rtl/map_table_restore_ctrl_if.sv - restore request, ROB read, map kill and free-list push signal bundle
interface map_table_restore_ctrl_if #(
  parameter int ROB_IDX_W = 4
);
  // branch-resolve request and ROB pointers
  logic                 restore_req_valid;
  logic [ROB_IDX_W-1:0] restore_req_rob_index;
  logic [ROB_IDX_W-1:0] rob_head_index;
  logic [ROB_IDX_W-1:0] rob_tail_index;

  // ROB read port
  logic [ROB_IDX_W-1:0] rob_read_index;
  logic                 rob_read_writes_reg;
  logic [4:0]           rob_read_dest_arch_reg_tag;
  logic [5:0]           rob_read_old_dest_phys_reg_tag;
  logic [5:0]           rob_read_new_dest_phys_reg_tag;

  // map table kill port
  logic                 kill_map_valid;
  logic [4:0]           kill_map_dest_arch_reg_tag;
  logic [5:0]           kill_map_old_dest_phys_reg_tag;
  logic [5:0]           kill_map_new_dest_phys_reg_tag;

  // free list push port
  logic                 free_push_valid;
  logic [5:0]           free_push_phys_reg_tag;
  logic                 free_push_ready;

  // status toward dispatch / ROB
  logic                 restore_busy;
  logic                 restore_done;
  logic [ROB_IDX_W-1:0] restore_new_tail;

  // environment side: resolve logic, ROB, map table and free list
  modport master (
    output restore_req_valid, restore_req_rob_index, rob_head_index, rob_tail_index,
    output rob_read_writes_reg, rob_read_dest_arch_reg_tag,
    output rob_read_old_dest_phys_reg_tag, rob_read_new_dest_phys_reg_tag,
    output free_push_ready,
    input  rob_read_index,
    input  kill_map_valid, kill_map_dest_arch_reg_tag,
    input  kill_map_old_dest_phys_reg_tag, kill_map_new_dest_phys_reg_tag,
    input  free_push_valid, free_push_phys_reg_tag,
    input  restore_busy, restore_done, restore_new_tail
  );

  // restore controller side
  modport slave (
    input  restore_req_valid, restore_req_rob_index, rob_head_index, rob_tail_index,
    input  rob_read_writes_reg, rob_read_dest_arch_reg_tag,
    input  rob_read_old_dest_phys_reg_tag, rob_read_new_dest_phys_reg_tag,
    input  free_push_ready,
    output rob_read_index,
    output kill_map_valid, kill_map_dest_arch_reg_tag,
    output kill_map_old_dest_phys_reg_tag, kill_map_new_dest_phys_reg_tag,
    output free_push_valid, free_push_phys_reg_tag,
    output restore_busy, restore_done, restore_new_tail
  );
endinterface

// File: rtl/map_table_restore_ctrl.sv
// rtl/map_table_restore_ctrl.sv - mispredict map-table restore walker; optional counters under MAP_RESTORE_PERF_CNT_EN
module map_table_restore_ctrl #(
  parameter int ROB_DEPTH = 16,
  parameter int ROB_IDX_W = $clog2(ROB_DEPTH)
) (
  input  logic CLK,
  input  logic nRST,
`ifdef MAP_RESTORE_PERF_CNT_EN
  output logic [15:0] perf_restore_count,
  output logic [15:0] perf_walk_cycles,
`endif
  map_table_restore_ctrl_if.slave ctrl
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ROB_IDX_W-1:0] IDX_ONE = ROB_IDX_W'(1);

  state_t               state_q, state_d;
  logic [ROB_IDX_W-1:0] ptr_q, ptr_d;
  logic [ROB_IDX_W-1:0] target_q, target_d;

  logic [ROB_IDX_W-1:0] ptr_dec;
  logic [ROB_IDX_W-1:0] tail_dec;
  logic [ROB_IDX_W-1:0] req_age;
  logic [ROB_IDX_W-1:0] tgt_age;
  logic [ROB_IDX_W-1:0] ptr_age;
  logic [ROB_IDX_W-1:0] walk_target;
  logic                 end_now;
  logic                 progress;

  logic                 rob_read_index_o;
  logic [ROB_IDX_W-1:0] rob_read_idx;
  logic                 kill_valid;
  logic [4:0]           kill_arch;
  logic [5:0]           kill_old;
  logic [5:0]           kill_new;
  logic                 push_valid;
  logic [5:0]           push_tag;
  logic                 busy;
  logic                 done;
  logic [ROB_IDX_W-1:0] new_tail;

  // ages are measured from the ROB head so wrapped indices compare correctly
  assign ptr_dec  = ptr_q - IDX_ONE;
  assign tail_dec = ctrl.rob_tail_index - IDX_ONE;
  assign req_age  = ctrl.restore_req_rob_index - ctrl.rob_head_index;
  assign tgt_age  = target_q - ctrl.rob_head_index;
  assign ptr_age  = ptr_q - ctrl.rob_head_index;

  // next-state, walk pointer, target and all port outputs
  always_comb begin
    state_d          = state_q;
    ptr_d            = ptr_q;
    target_d         = target_q;
    walk_target      = target_q;
    end_now          = 1'b0;
    progress         = 1'b0;
    rob_read_index_o = 1'b0;
    kill_valid       = 1'b0;
    kill_arch        = '0;
    kill_old         = '0;
    kill_new         = '0;
    push_valid       = 1'b0;
    push_tag         = '0;
    busy             = 1'b0;
    done             = 1'b0;
    new_tail         = '0;

    case (state_q)
      IDLE: begin
        busy = ctrl.restore_req_valid;
        if (ctrl.restore_req_valid) begin
          target_d = ctrl.restore_req_rob_index;
          if (tail_dec == ctrl.restore_req_rob_index) begin
            // mispredicting instruction is the youngest: nothing to undo
            state_d = DONE;
          end else begin
            ptr_d   = tail_dec;
            state_d = WALK;
          end
        end
      end

      WALK: begin
        busy             = 1'b1;
        rob_read_index_o = 1'b1;
        // an older mispredict extends the walk; younger or equal ones are dropped
        if (ctrl.restore_req_valid && (req_age < tgt_age)) begin
          target_d    = ctrl.restore_req_rob_index;
          walk_target = ctrl.restore_req_rob_index;
          end_now     = (ptr_age <= req_age);
        end

        if (end_now) begin
          state_d = DONE;
        end else begin
          // a writing entry only retires once the free list can take its register
          progress = !ctrl.rob_read_writes_reg || ctrl.free_push_ready;
          if (ctrl.rob_read_writes_reg && ctrl.free_push_ready) begin
            kill_valid = 1'b1;
            kill_arch  = ctrl.rob_read_dest_arch_reg_tag;
            kill_old   = ctrl.rob_read_old_dest_phys_reg_tag;
            kill_new   = ctrl.rob_read_new_dest_phys_reg_tag;
            push_valid = 1'b1;
            push_tag   = ctrl.rob_read_new_dest_phys_reg_tag;
          end
          if (progress) begin
            if (ptr_dec == walk_target) begin
              state_d = DONE;
            end else begin
              ptr_d = ptr_dec;
            end
          end
        end
      end

      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        new_tail = target_q + IDX_ONE;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    rob_read_idx = rob_read_index_o ? ptr_q : '0;
  end

  assign ctrl.rob_read_index                 = rob_read_idx;
  assign ctrl.kill_map_valid                 = kill_valid;
  assign ctrl.kill_map_dest_arch_reg_tag     = kill_arch;
  assign ctrl.kill_map_old_dest_phys_reg_tag = kill_old;
  assign ctrl.kill_map_new_dest_phys_reg_tag = kill_new;
  assign ctrl.free_push_valid                = push_valid;
  assign ctrl.free_push_phys_reg_tag         = push_tag;
  assign ctrl.restore_busy                   = busy;
  assign ctrl.restore_done                   = done;
  assign ctrl.restore_new_tail               = new_tail;

  // walker state registers; reset abandons any partial walk
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      target_q <= target_d;
    end
  end

`ifdef MAP_RESTORE_PERF_CNT_EN
  logic [15:0] perf_restore_count_q, perf_restore_count_d;
  logic [15:0] perf_walk_cycles_q, perf_walk_cycles_d;

  // saturating event counters: completed restores and walk cycles (stalls included)
  always_comb begin
    perf_restore_count_d = perf_restore_count_q;
    perf_walk_cycles_d   = perf_walk_cycles_q;
    if ((state_q == DONE) && (perf_restore_count_q != 16'hFFFF)) begin
      perf_restore_count_d = perf_restore_count_q + 16'd1;
    end
    if ((state_q == WALK) && (perf_walk_cycles_q != 16'hFFFF)) begin
      perf_walk_cycles_d = perf_walk_cycles_q + 16'd1;
    end
  end

  // counter registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      perf_restore_count_q <= '0;
      perf_walk_cycles_q   <= '0;
    end else begin
      perf_restore_count_q <= perf_restore_count_d;
      perf_walk_cycles_q   <= perf_walk_cycles_d;
    end
  end

  assign perf_restore_count = perf_restore_count_q;
  assign perf_walk_cycles   = perf_walk_cycles_q;
`endif

endmodule

// File: tb/tb_map_table_restore_ctrl.sv
// tb/tb_map_table_restore_ctrl.sv - directed self-checking bench for map_table_restore_ctrl
module tb_map_table_restore_ctrl;

  logic clk;
  logic nrst;

  map_table_restore_ctrl_if #(.ROB_IDX_W(4)) bus ();

`ifdef MAP_RESTORE_PERF_CNT_EN
  logic [15:0] perf_restore_count;
  logic [15:0] perf_walk_cycles;
`endif

  map_table_restore_ctrl #(.ROB_DEPTH(16)) dut (
    .CLK  (clk),
    .nRST (nrst),
`ifdef MAP_RESTORE_PERF_CNT_EN
    .perf_restore_count (perf_restore_count),
    .perf_walk_cycles   (perf_walk_cycles),
`endif
    .ctrl (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROB contents model, read combinationally at the DUT read address
  logic       rob_wr   [16];
  logic [4:0] rob_arch [16];
  logic [5:0] rob_old  [16];
  logic [5:0] rob_new  [16];

  always_comb begin
    bus.rob_read_writes_reg            = rob_wr[bus.rob_read_index];
    bus.rob_read_dest_arch_reg_tag     = rob_arch[bus.rob_read_index];
    bus.rob_read_old_dest_phys_reg_tag = rob_old[bus.rob_read_index];
    bus.rob_read_new_dest_phys_reg_tag = rob_new[bus.rob_read_index];
  end

  int n_checks = 0;
  int n_pass   = 0;

  int push_q[$];
  int arch_q[$];
  int read_q[$];
  int tail_seen;
  int busy_at_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic fill_rob();
    for (int i = 0; i < 16; i++) begin
      rob_wr[i]   = 1'b1;
      rob_arch[i] = 5'(i);
      rob_old[i]  = 6'(16 + i);
      rob_new[i]  = 6'(32 + i);
    end
  endtask

  task automatic set_rob(input int i, input logic wr, input int arch, input int old_p, input int new_p);
    rob_wr[i]   = wr;
    rob_arch[i] = 5'(arch);
    rob_old[i]  = 6'(old_p);
    rob_new[i]  = 6'(new_p);
  endtask

  // presents a request for one cycle; returns at the first cycle after acceptance
  task automatic do_req(input int head, input int tail, input int idx);
    @(negedge clk);
    bus.rob_head_index        = 4'(head);
    bus.rob_tail_index        = 4'(tail);
    bus.restore_req_valid     = 1'b1;
    bus.restore_req_rob_index = 4'(idx);
    #1;
    check("req_busy", bus.restore_busy, 1);
    @(negedge clk);
    bus.restore_req_valid = 1'b0;
  endtask

  // records reads and kills until restore_done, then checks the pulse ends
  task automatic collect(input int max_cyc);
    bit seen;
    seen = 1'b0;
    push_q.delete();
    arch_q.delete();
    read_q.delete();
    tail_seen    = -1;
    busy_at_done = 0;
    for (int c = 0; c < max_cyc; c++) begin
      #1;
      if (bus.restore_done) begin
        seen         = 1'b1;
        tail_seen    = int'(bus.restore_new_tail);
        busy_at_done = int'(bus.restore_busy);
        break;
      end
      check("kill_eq_push", bus.kill_map_valid, bus.free_push_valid);
      read_q.push_back(int'(bus.rob_read_index));
      if (bus.kill_map_valid) begin
        push_q.push_back(int'(bus.free_push_phys_reg_tag));
        arch_q.push_back(int'(bus.kill_map_dest_arch_reg_tag));
      end
      @(negedge clk);
    end
    check("done_seen", seen, 1);
    check("busy_at_done", busy_at_done, 1);
    @(negedge clk);
    #1;
    check("done_one_cycle", bus.restore_done, 0);
    check("busy_clear", bus.restore_busy, 0);
  endtask

  initial begin
    nrst                      = 1'b0;
    bus.restore_req_valid     = 1'b0;
    bus.restore_req_rob_index = '0;
    bus.rob_head_index        = '0;
    bus.rob_tail_index        = '0;
    bus.free_push_ready       = 1'b1;
    fill_rob();

    // reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", bus.restore_busy, 0);
    check("rst_done", bus.restore_done, 0);
    check("rst_kill", bus.kill_map_valid, 0);
    check("rst_push", bus.free_push_valid, 0);
    check("rst_read_idx", bus.rob_read_index, 0);
    check("rst_new_tail", bus.restore_new_tail, 0);
    @(negedge clk);
    nrst = 1'b1;

    // empty walk: mispredict is youngest
    do_req(0, 4, 3);
    collect(5);
    check("empty_reads", read_q.size(), 0);
    check("empty_pushes", push_q.size(), 0);
    check("empty_new_tail", tail_seen, 4);

    // basic walk of entries 4,3,2
    set_rob(4, 1'b1, 7, 10, 40);
    set_rob(3, 1'b1, 8, 11, 41);
    set_rob(2, 1'b1, 9, 12, 42);
    do_req(0, 5, 1);
    collect(10);
    check("basic_n", push_q.size(), 3);
    check("basic_push0", push_q[0], 40);
    check("basic_push1", push_q[1], 41);
    check("basic_push2", push_q[2], 42);
    check("basic_arch0", arch_q[0], 7);
    check("basic_arch1", arch_q[1], 8);
    check("basic_arch2", arch_q[2], 9);
    check("basic_read0", read_q[0], 4);
    check("basic_read2", read_q[2], 2);
    check("basic_new_tail", tail_seen, 2);

    // non-writing entry 3 advances without kill or push
    set_rob(3, 1'b0, 8, 11, 41);
    do_req(0, 5, 1);
    collect(10);
    check("nowr_reads", read_q.size(), 3);
    check("nowr_read1", read_q[1], 3);
    check("nowr_n", push_q.size(), 2);
    check("nowr_push0", push_q[0], 40);
    check("nowr_push1", push_q[1], 42);
    check("nowr_new_tail", tail_seen, 2);
    set_rob(3, 1'b1, 8, 11, 41);

    // wrap from 0 to 15
    set_rob(1, 1'b1, 3, 20, 50);
    set_rob(0, 1'b1, 4, 21, 51);
    do_req(14, 2, 15);
    collect(10);
    check("wrap_reads", read_q.size(), 2);
    check("wrap_read0", read_q[0], 1);
    check("wrap_read1", read_q[1], 0);
    check("wrap_push0", push_q[0], 50);
    check("wrap_push1", push_q[1], 51);
    check("wrap_new_tail", tail_seen, 0);

    // free list backpressure on entry 3
    do_req(0, 5, 1);
    #1;
    check("bp_first_idx", bus.rob_read_index, 4);
    check("bp_first_kill", bus.kill_map_valid, 1);
    @(negedge clk);
    bus.free_push_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_kill", bus.kill_map_valid, 0);
      check("bp_push", bus.free_push_valid, 0);
      check("bp_kill_arch", bus.kill_map_dest_arch_reg_tag, 0);
      check("bp_idx_hold", bus.rob_read_index, 3);
      check("bp_busy", bus.restore_busy, 1);
      @(negedge clk);
    end
    bus.free_push_ready = 1'b1;
    #1;
    check("bp_resume_idx", bus.rob_read_index, 3);
    check("bp_resume_kill", bus.kill_map_valid, 1);
    check("bp_resume_push", bus.free_push_phys_reg_tag, 41);
    check("bp_resume_old", bus.kill_map_old_dest_phys_reg_tag, 11);
    @(negedge clk);
    collect(10);
    check("bp_tail_pushes", push_q.size(), 1);
    check("bp_last_push", push_q[0], 42);
    check("bp_new_tail", tail_seen, 2);

    // retarget: older request extends the walk, younger one is ignored
    fill_rob();
    do_req(0, 8, 5);
    #1;
    check("rt_idx7", bus.rob_read_index, 7);
    @(negedge clk);
    bus.restore_req_valid     = 1'b1;
    bus.restore_req_rob_index = 4'd2;
    #1;
    check("rt_idx6", bus.rob_read_index, 6);
    check("rt_push6", bus.free_push_phys_reg_tag, 38);
    @(negedge clk);
    bus.restore_req_rob_index = 4'd6;
    #1;
    check("rt_idx5", bus.rob_read_index, 5);
    check("rt_kill5", bus.kill_map_valid, 1);
    @(negedge clk);
    bus.restore_req_valid = 1'b0;
    collect(10);
    check("rt_reads", read_q.size(), 2);
    check("rt_read0", read_q[0], 4);
    check("rt_read1", read_q[1], 3);
    check("rt_push_last", push_q[1], 35);
    check("rt_new_tail", tail_seen, 3);

    // asynchronous reset mid-walk
    do_req(0, 8, 1);
    #1;
    check("rst_mid_kill_pre", bus.kill_map_valid, 1);
    nrst = 1'b0;
    #1;
    check("rst_mid_busy", bus.restore_busy, 0);
    check("rst_mid_kill", bus.kill_map_valid, 0);
    check("rst_mid_push", bus.free_push_valid, 0);
    check("rst_mid_idx", bus.rob_read_index, 0);
    check("rst_mid_arch", bus.kill_map_dest_arch_reg_tag, 0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    #1;
    check("rst_after_busy", bus.restore_busy, 0);
    check("rst_after_done", bus.restore_done, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
